// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } hz_state_t;

  localparam logic [4:0] X0 = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_raw_detect.sv
// Compares one decode source register against the in-flight destinations.
module raw_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int WB_BYPASS = 1
) (
  input  logic [4:0] src,
  input  logic       used,
  input  logic [4:0] ex_rd,
  input  logic       ex_wen,
  input  logic [4:0] mem_rd,
  input  logic       mem_wen,
  input  logic [4:0] wb_rd,
  input  logic       wb_wen,
  output logic       hit
);

  // With write-through register file the WB writer is already visible to Dec.
  localparam bit CHECK_WB = (WB_BYPASS == 0);

  always_comb begin
    hit = 1'b0;
    if (used && (src != X0)) begin
      hit = (ex_wen && (ex_rd == src)) ||
            (mem_wen && (mem_rd == src)) ||
            (CHECK_WB && wb_wen && (wb_rd == src));
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/bubble/flush/freeze sequencing with drain-and-halt and
// saturating stall/flush performance counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int WB_BYPASS    = 1,
  parameter int DRAIN_CYCLES = 4,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_rs1_used,
  input  logic             dec_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             ex_wen,
  input  logic             mem_wen,
  input  logic             wb_wen,
  input  logic             redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_in,
  output logic             stall_front,
  output logic             bubble_ex,
  output logic             flush,
  output logic             freeze,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_MAX   = WW'(MEM_TIMEOUT);

  hz_state_t        state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [WW-1:0]    wait_q, wait_d, wait_inc;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hit_rs1, hit_rs2, raw, mem_stall;

  raw_detect #(.WB_BYPASS(WB_BYPASS)) u_raw_rs1 (
    .src     (dec_rs1),
    .used    (dec_rs1_used),
    .ex_rd   (ex_rd),
    .ex_wen  (ex_wen),
    .mem_rd  (mem_rd),
    .mem_wen (mem_wen),
    .wb_rd   (wb_rd),
    .wb_wen  (wb_wen),
    .hit     (hit_rs1)
  );

  raw_detect #(.WB_BYPASS(WB_BYPASS)) u_raw_rs2 (
    .src     (dec_rs2),
    .used    (dec_rs2_used),
    .ex_rd   (ex_rd),
    .ex_wen  (ex_wen),
    .mem_rd  (mem_rd),
    .mem_wen (mem_wen),
    .wb_rd   (wb_rd),
    .wb_wen  (wb_wen),
    .hit     (hit_rs2)
  );

  assign raw       = dec_valid && (hit_rs1 || hit_rs2);
  assign mem_stall = dmem_req && !dmem_ready;
  // wait_q is zero outside MEM_WAIT, so this is the running frozen-cycle count.
  assign wait_inc  = wait_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    wait_d      = wait_q;
    mem_err_d   = mem_err_q;
    stall_front = 1'b0;
    bubble_ex   = 1'b0;
    flush       = 1'b0;
    freeze      = 1'b0;

    unique case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_stall) begin
          freeze = 1'b1;
          if (wait_inc >= WAIT_MAX) begin
            mem_err_d = 1'b1;
            state_d   = RUN;
            wait_d    = '0;
          end else begin
            state_d = MEM_WAIT;
            wait_d  = wait_inc;
          end
        end else begin
          // The release cycle of a memory wait lets the pipeline advance, so it
          // must honour hazards, redirects and halts exactly like RUN.
          state_d = RUN;
          wait_d  = '0;
          if (redirect) begin
            flush     = 1'b1;
            bubble_ex = 1'b1;
          end else begin
            stall_front = raw;
            bubble_ex   = raw;
            if (halt_in) begin
              state_d = DRAIN;
              drain_d = '0;
            end
          end
        end
      end
      DRAIN: begin
        if (mem_stall) begin
          freeze = 1'b1;
        end else if (redirect) begin
          flush     = 1'b1;
          bubble_ex = 1'b1;
          state_d   = RUN;
        end else begin
          stall_front = 1'b1;
          bubble_ex   = 1'b1;
          if (drain_q == DRAIN_LAST) begin
            state_d = HALTED;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
      end
      HALTED: begin
        if (mem_stall) begin
          freeze = 1'b1;
        end else begin
          stall_front = 1'b1;
          bubble_ex   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q != HALTED) begin
      if ((stall_front || freeze) && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (flush && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      drain_q     <= '0;
      wait_q      <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      wait_q      <= wait_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halted      = (state_q == HALTED);
  assign mem_err     = mem_err_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: combinational vector table plus
// clocked sequences for freeze, drain/halt, wrong-path halt and timeout.
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             dec_valid, dec_rs1_used, dec_rs2_used;
  logic [4:0]       dec_rs1, dec_rs2, ex_rd, mem_rd, wb_rd;
  logic             ex_wen, mem_wen, wb_wen;
  logic             redirect, dmem_req, dmem_ready, halt_in;
  logic             stall_front, bubble_ex, flush, freeze, halted, mem_err;
  logic [CNT_W-1:0] stall_count, flush_count;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_hazard_ctrl #(
    .CNT_W(CNT_W), .WB_BYPASS(1), .DRAIN_CYCLES(4), .MEM_TIMEOUT(255)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dec_valid    (dec_valid),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rs1_used (dec_rs1_used),
    .dec_rs2_used (dec_rs2_used),
    .ex_rd        (ex_rd),
    .mem_rd       (mem_rd),
    .wb_rd        (wb_rd),
    .ex_wen       (ex_wen),
    .mem_wen      (mem_wen),
    .wb_wen       (wb_wen),
    .redirect     (redirect),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .halt_in      (halt_in),
    .stall_front  (stall_front),
    .bubble_ex    (bubble_ex),
    .flush        (flush),
    .freeze       (freeze),
    .halted       (halted),
    .mem_err      (mem_err),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       dv;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] exrd, memrd, wbrd;
    logic       exw, memw, wbw;
    logic       redir, req, rdy, halt;
    logic       e_stall, e_bub, e_flush, e_frz;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic dv, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2,
                              input logic [4:0] exrd, input logic exw,
                              input logic [4:0] memrd, input logic memw,
                              input logic [4:0] wbrd, input logic wbw,
                              input logic redir, input logic req, input logic rdy,
                              input logic [3:0] exp);
    vec_t v;
    v.dv = dv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.exrd = exrd; v.exw = exw; v.memrd = memrd; v.memw = memw;
    v.wbrd = wbrd; v.wbw = wbw; v.redir = redir; v.req = req; v.rdy = rdy;
    v.halt = 1'b0;
    {v.e_stall, v.e_bub, v.e_flush, v.e_frz} = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rs1_used = 0; dec_rs2_used = 0;
    ex_rd = 0; mem_rd = 0; wb_rd = 0; ex_wen = 0; mem_wen = 0; wb_wen = 0;
    redirect = 0; dmem_req = 0; dmem_ready = 0; halt_in = 0;
  endtask

  task automatic apply(input vec_t v);
    dec_valid = v.dv; dec_rs1 = v.rs1; dec_rs2 = v.rs2;
    dec_rs1_used = v.u1; dec_rs2_used = v.u2;
    ex_rd = v.exrd; mem_rd = v.memrd; wb_rd = v.wbrd;
    ex_wen = v.exw; mem_wen = v.memw; wb_wen = v.wbw;
    redirect = v.redir; dmem_req = v.req; dmem_ready = v.rdy; halt_in = v.halt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    #2 reset = 1'b0;
    #1;
    check("rst_state", 32'(dut.state_q), 32'(RUN));
    check("rst_mem_err", 32'(mem_err), 0);
    check("rst_stall_count", stall_count, 0);
    check("rst_flush_count", flush_count, 0);
    check("rst_halted", 32'(halted), 0);
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    // dv rs1 u1 rs2 u2 exrd exw memrd memw wbrd wbw redir req rdy {stall,bub,flush,frz}
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    vecs[1]  = mk(1, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 4'b1100);
    vecs[2]  = mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    vecs[3]  = mk(1, 1, 0, 7, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 4'b1100);
    vecs[4]  = mk(1, 1, 0, 7, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 4'b0000);
    vecs[5]  = mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 4'b0000);
    vecs[6]  = mk(0, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    vecs[7]  = mk(1, 5, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    vecs[8]  = mk(1, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0, 0, 4'b0110);
    vecs[9]  = mk(1, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0, 1, 1, 0, 4'b0001);
    vecs[10] = mk(1, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, 1, 4'b1100);
    vecs[11] = mk(1, 3, 1, 0, 0, 4, 1, 3, 0, 0, 0, 0, 0, 0, 4'b0000);

    idle();
    #12 reset = 1'b1;
    @(negedge clk); #1;
    check("reset_stall_front", 32'(stall_front), 0);
    check("reset_bubble_ex", 32'(bubble_ex), 0);
    check("reset_flush", 32'(flush), 0);
    check("reset_freeze", 32'(freeze), 0);
    check("reset_halted", 32'(halted), 0);
    check("reset_mem_err", 32'(mem_err), 0);
    check("reset_stall_count", stall_count, 0);
    check("reset_flush_count", flush_count, 0);

    // Combinational table: inputs return to idle before each rising edge.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      check($sformatf("vec%0d_stall_front", i), 32'(stall_front), 32'(vecs[i].e_stall));
      check($sformatf("vec%0d_bubble_ex", i), 32'(bubble_ex), 32'(vecs[i].e_bub));
      check($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].e_flush));
      check($sformatf("vec%0d_freeze", i), 32'(freeze), 32'(vecs[i].e_frz));
      #1 idle();
    end

    // Redirect with RAW, clocked: flush_count 0 -> 1.
    @(negedge clk);
    check("pre_flush_count", flush_count, 0);
    apply(vecs[8]);
    @(negedge clk);
    idle();
    #1;
    check("redir_flush_count", flush_count, 1);
    check("redir_stall_count", stall_count, 0);

    // Three frozen cycles, then ready.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dmem_req = 1; dmem_ready = 0;
      #1 check($sformatf("frz_cycle%0d", i), 32'(freeze), 1);
    end
    @(negedge clk);
    dmem_ready = 1;
    #1 check("frz_release", 32'(freeze), 0);
    @(negedge clk);
    idle();
    #1;
    check("frz_stall_count", stall_count, 3);
    check("frz_state_run", 32'(dut.state_q), 32'(RUN));

    // Halt pulse: four drain cycles, halted on the fifth.
    @(negedge clk);
    halt_in = 1;
    #1 check("halt_cycle_stall", 32'(stall_front), 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      idle();
      #1;
      check($sformatf("drain%0d_stall_front", i), 32'(stall_front), 1);
      check($sformatf("drain%0d_bubble_ex", i), 32'(bubble_ex), 1);
      check($sformatf("drain%0d_halted", i), 32'(halted), 0);
    end
    @(negedge clk); #1;
    check("halted_set", 32'(halted), 1);
    check("halted_stall_front", 32'(stall_front), 1);
    redirect = 1;
    #1 check("halted_redirect_flush", 32'(flush), 0);
    @(negedge clk);
    redirect = 0;
    #1;
    check("halted_after_redirect", 32'(halted), 1);
    check("halted_flush_count", flush_count, 1);
    check("halted_stall_count", stall_count, 7);

    do_reset();

    // Halt on a wrong path: redirect two cycles later.
    @(negedge clk);
    halt_in = 1;
    @(negedge clk);
    idle();
    @(negedge clk);
    redirect = 1;
    #1;
    check("wrongpath_flush", 32'(flush), 1);
    check("wrongpath_stall_front", 32'(stall_front), 0);
    check("wrongpath_bubble_ex", 32'(bubble_ex), 1);
    @(negedge clk);
    idle();
    #1 check("wrongpath_state_run", 32'(dut.state_q), 32'(RUN));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      check($sformatf("wrongpath_halted%0d", i), 32'(halted), 0);
    end
    check("wrongpath_flush_count", flush_count, 1);

    do_reset();

    // Memory timeout after 255 frozen cycles.
    @(negedge clk);
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 254; i++) @(negedge clk);
    #1 check("timeout_before", 32'(mem_err), 0);
    @(negedge clk); #1;
    check("timeout_set", 32'(mem_err), 1);
    check("timeout_stall_count", stall_count, 255);
    idle();
    for (int i = 0; i < 5; i++) @(negedge clk);
    #1 check("timeout_sticky", 32'(mem_err), 1);

    // Asynchronous reset in the middle of a wait.
    dmem_req = 1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    #2 check("midwait_state", 32'(dut.state_q), 32'(MEM_WAIT));
    idle();
    reset = 1'b0;
    #1;
    check("async_rst_state", 32'(dut.state_q), 32'(RUN));
    check("async_rst_mem_err", 32'(mem_err), 0);
    check("async_rst_stall_count", stall_count, 0);
    check("async_rst_freeze", 32'(freeze), 0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central sequencing controller for the 5-stage pipeline (IF, Dec, Exec, Mem, WB). It drives the pipeline's stall, bubble, flush and freeze controls from three sources: decode-stage RAW hazards (the pipeline has no forwarding), Mem-stage branch redirects, and variable-latency data-memory waits. It also sequences an orderly drain-and-halt when IF fetches a halt instruction, and keeps saturating stall and flush performance counters.

## Interface
Parameters:
- CNT_W, 32: width of the performance counters.
- WB_BYPASS, 1: 1 = register file writes through to same-cycle reads, so the WB stage is excluded from RAW checks.
- DRAIN_CYCLES, 4: cycles spent in DRAIN before HALTED.
- MEM_TIMEOUT, 255: maximum consecutive MEM_WAIT cycles before `mem_err` is set.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- dec_valid  in  1  Dec stage holds a real instruction
- dec_rs1, dec_rs2  in  5 each  Dec source registers
- dec_rs1_used, dec_rs2_used  in  1 each  the corresponding source is read
- ex_rd, mem_rd, wb_rd  in  5 each  destination register per stage
- ex_wen, mem_wen, wb_wen  in  1 each  register write-enable per stage
- redirect  in  1  Mem-stage taken branch or jump (npc_control)
- dmem_req  in  1  Mem stage is accessing data memory this cycle
- dmem_ready  in  1  data memory completes this cycle
- halt_in  in  1  IF fetched a halt instruction
- stall_front  out  1  hold PC and IF/Dec registers
- bubble_ex  out  1  load zeroed controls into the Exec register
- flush  out  1  clear IF/Dec and Dec/Exec contents
- freeze  out  1  hold every pipeline register
- halted  out  1  pipeline drained and stopped (registered)
- mem_err  out  1  sticky memory-timeout flag (registered)
- stall_count  out  CNT_W  saturating count of stall cycles
- flush_count  out  CNT_W  saturating count of flush events

## Operation
- **RAW hazard:** `raw = dec_valid && (hit(rs1) || hit(rs2))`.
  - `hit(r) = used && r != 0 && ((ex_wen && ex_rd == r) || (mem_wen && mem_rd == r) || (!WB_BYPASS && wb_wen && wb_rd == r))`.
  - Register x0 never causes a hazard.
- **Combinational priority** (highest first):
  1. `freeze = dmem_req && !dmem_ready`. All other outputs are 0 while frozen.
  2. `flush = redirect`. Forces `stall_front = 0`; also sets `bubble_ex = 1`.
  3. RAW in RUN: `stall_front = 1`, `bubble_ex = 1`.
- **States:** RUN, MEM_WAIT, DRAIN, HALTED.
  - **RUN:**
    - `freeze` → MEM_WAIT.
    - `halt_in && !redirect && !freeze` → DRAIN with the drain counter loaded to 0.
  - **MEM_WAIT:**
    - `freeze` stays driven by the live inputs.
    - Returns to RUN in the cycle after `dmem_ready` (or after `dmem_req` drops).
    - A wait counter increments each frozen cycle. Reaching MEM_TIMEOUT sets `mem_err` and returns to RUN.
    - `mem_err` clears only on reset.
  - **DRAIN:**
    - `stall_front = 1` and `bubble_ex = 1` every cycle.
    - Drain counter increments when not frozen. On reaching DRAIN_CYCLES-1 → HALTED.
    - `redirect` in DRAIN means the halt was on a wrong path: `flush` asserts and the state returns to RUN.
  - **HALTED:**
    - `halted = 1`, `stall_front = 1`, `bubble_ex = 1`.
    - `redirect` is ignored. Exit is by reset only.
- **Counters:**
  - `stall_count` increments in each cycle where `stall_front || freeze`.
  - `flush_count` increments in each cycle where `flush`.
  - Both saturate at all-ones. Neither counts while HALTED.

## Timing
- `stall_front`, `bubble_ex`, `flush` and `freeze` have zero latency: they are combinational from the inputs and the current state.
- `halted` asserts on the first cycle in HALTED, exactly DRAIN_CYCLES non-frozen cycles after the `halt_in` cycle.
- Reset (asynchronous, any state):
  - State, counters, `halted` and `mem_err` all go to 0 (state RUN).
  - With all inputs at 0, every output is 0.
- Coincident events:
  - `halt_in` with `redirect`: the halt is discarded.
  - `redirect` with `freeze`: the redirect is held off. It must remain asserted, which it does because the Mem register is frozen.
- A RAW condition lasts at most 2 cycles with WB_BYPASS=1, or 3 with WB_BYPASS=0. The controller does not bound this.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the state enum `hz_state_t` (RUN, MEM_WAIT, DRAIN, HALTED);
  - the `X0` register constant.
- Sub-module `raw_detect`: purely combinational. It compares one source register against the three stage destinations and is instantiated twice (rs1, rs2).
- The top level contains the FSM, the drain and wait counters, and the performance counters.

## Test plan
- RAW on rs1: `dec_rs1 = 5`, used, `ex_rd = 5`, `ex_wen = 1` → `stall_front = 1`, `bubble_ex = 1`. Repeat with `dec_rs1 = 0` → no stall.
- Redirect with simultaneous RAW → `flush = 1`, `stall_front = 0`, `bubble_ex = 1`; `flush_count` goes 0 → 1.
- `dmem_req = 1` with `dmem_ready` low for 3 cycles, then high → `freeze` high for exactly 3 cycles, `stall_count = 3`, state back in RUN.
- `halt_in` pulse in RUN → `stall_front` high for 4 cycles, then `halted = 1` on the 5th cycle; a later `redirect` is ignored.
- `halt_in`, then `redirect` 2 cycles later → `flush = 1`, state RUN, `halted` never asserts.
- `dmem_ready` held low for 255 cycles → `mem_err = 1`, persisting until reset; an asynchronous reset mid-wait clears the state, counters and `mem_err` immediately.
